// File: rtl/ocx_tlx_credit_pkg.sv
// Shared types and limits for the TLX receive-side credit-return scheduler.
package ocx_tlx_credit_pkg;
    localparam int PEND_W        = 8;
    localparam int VC_FIELD_MAX  = 15;
    localparam int DCP_FIELD_MAX = 63;
    localparam int NUM_CLS       = 4;

    typedef enum logic [1:0] {IDLE, ARM, SEND} sched_state_t;
    typedef enum logic [1:0] {VC0, VC1, DCP0, DCP1} cred_cls_t;
endpackage

// File: rtl/ocx_tlx_credit_acc.sv
// One credit class: saturating pending counter, request snapshot clamped to the
// return-field limit, and the trigger flags the scheduler needs.
module ocx_tlx_credit_acc
    import ocx_tlx_credit_pkg::*;
#(
    parameter int INIT      = 16,
    parameter int FIELD_MAX = VC_FIELD_MAX,
    parameter int FW        = 4,
    parameter int THRESH    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          free,
    input  logic          accept,
    input  logic          snap,
    output logic [FW-1:0] taken,
    output logic          nonzero,
    output logic          at_thresh,
    output logic          next_zero,
    output logic          ovf
);
    localparam int SW = PEND_W + 1;

    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_next;
    logic [SW-1:0]     sum;
    logic [FW-1:0]     snap_val;

    // taken never exceeds pending, so the extra bit only catches overflow past INIT
    always_comb begin
        sum          = {1'b0, pending} + SW'(free) - (accept ? SW'(taken) : '0);
        ovf          = !clear && !load && (sum > SW'(INIT));
        pending_next = (sum > SW'(INIT)) ? PEND_W'(INIT) : sum[PEND_W-1:0];
        snap_val     = (pending > PEND_W'(FIELD_MAX)) ? FW'(FIELD_MAX) : pending[FW-1:0];
    end

    assign next_zero = (pending_next == '0);
    assign nonzero   = (pending != '0);
    assign at_thresh = (pending >= PEND_W'(THRESH));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pending <= '0;
            taken   <= '0;
        end else if (load) begin
            pending <= PEND_W'(INIT);
        end else begin
            pending <= pending_next;
            if (snap) taken <= snap_val;
        end
    end
endmodule

// File: rtl/ocx_tlx_rcv_credit_sched.sv
// TLX receive credit-return scheduler: initial grant at link-up, then batched returns.
// Build macro OCX_TLX_CREDIT_STATS_EN adds running totals of returned credits.
module ocx_tlx_rcv_credit_sched
    import ocx_tlx_credit_pkg::*;
#(
    parameter int INIT_VC0    = 16,
    parameter int INIT_VC1    = 32,
    parameter int INIT_DCP0   = 64,
    parameter int INIT_DCP1   = 64,
    parameter int CRED_THRESH = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic       tlx_clk,
    input  logic       reset,
    input  logic       link_up,
    input  logic       vc0_release,
    input  logic       vc1_release,
    input  logic       dcp0_release,
    input  logic       dcp1_release,
    input  logic       credit_ret_ack,
    output logic       credit_ret_v,
    output logic [3:0] credit_ret_vc0,
    output logic [3:0] credit_ret_vc1,
    output logic [5:0] credit_ret_dcp0,
    output logic [5:0] credit_ret_dcp1,
    output logic       init_done,
    output logic       credit_ovf_err
`ifdef OCX_TLX_CREDIT_STATS_EN
    ,
    output logic [15:0] credit_ret_total_vc0,
    output logic [15:0] credit_ret_total_vc1,
    output logic [15:0] credit_ret_total_dcp
`endif
);
    sched_state_t       state;
    logic [7:0]         timer;
    logic               init_phase;
    logic [NUM_CLS-1:0] rel, nz, thr, nxz, ovf;
    logic               clear, load, accept, go, any_nz;

    assign rel    = {dcp1_release, dcp0_release, vc1_release, vc0_release};
    assign clear  = !link_up;
    assign load   = (state == IDLE) && link_up;
    assign accept = (state == SEND) && link_up && credit_ret_ack;
    assign any_nz = |nz;
    assign go     = (state == ARM) && link_up && any_nz &&
                    (init_phase || (|thr) || (timer >= 8'(TIMEOUT - 1)));

    ocx_tlx_credit_acc #(.INIT(INIT_VC0), .FIELD_MAX(VC_FIELD_MAX), .FW(4), .THRESH(CRED_THRESH)) u_vc0 (
        .clk(tlx_clk), .reset(reset), .clear(clear), .load(load), .free(rel[VC0]),
        .accept(accept), .snap(go), .taken(credit_ret_vc0), .nonzero(nz[VC0]),
        .at_thresh(thr[VC0]), .next_zero(nxz[VC0]), .ovf(ovf[VC0])
    );
    ocx_tlx_credit_acc #(.INIT(INIT_VC1), .FIELD_MAX(VC_FIELD_MAX), .FW(4), .THRESH(CRED_THRESH)) u_vc1 (
        .clk(tlx_clk), .reset(reset), .clear(clear), .load(load), .free(rel[VC1]),
        .accept(accept), .snap(go), .taken(credit_ret_vc1), .nonzero(nz[VC1]),
        .at_thresh(thr[VC1]), .next_zero(nxz[VC1]), .ovf(ovf[VC1])
    );
    ocx_tlx_credit_acc #(.INIT(INIT_DCP0), .FIELD_MAX(DCP_FIELD_MAX), .FW(6), .THRESH(CRED_THRESH)) u_dcp0 (
        .clk(tlx_clk), .reset(reset), .clear(clear), .load(load), .free(rel[DCP0]),
        .accept(accept), .snap(go), .taken(credit_ret_dcp0), .nonzero(nz[DCP0]),
        .at_thresh(thr[DCP0]), .next_zero(nxz[DCP0]), .ovf(ovf[DCP0])
    );
    ocx_tlx_credit_acc #(.INIT(INIT_DCP1), .FIELD_MAX(DCP_FIELD_MAX), .FW(6), .THRESH(CRED_THRESH)) u_dcp1 (
        .clk(tlx_clk), .reset(reset), .clear(clear), .load(load), .free(rel[DCP1]),
        .accept(accept), .snap(go), .taken(credit_ret_dcp1), .nonzero(nz[DCP1]),
        .at_thresh(thr[DCP1]), .next_zero(nxz[DCP1]), .ovf(ovf[DCP1])
    );

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= '0;
            init_phase     <= 1'b0;
            init_done      <= 1'b0;
            credit_ret_v   <= 1'b0;
            credit_ovf_err <= 1'b0;
        end else begin
            if (|ovf) credit_ovf_err <= 1'b1;
            // Link loss abandons any in-flight request; the error flag survives
            if (!link_up) begin
                state        <= IDLE;
                timer        <= '0;
                init_phase   <= 1'b0;
                init_done    <= 1'b0;
                credit_ret_v <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        init_phase <= 1'b1;
                        state      <= ARM;
                    end
                    ARM: begin
                        timer <= any_nz ? timer + 8'd1 : '0;
                        if (go) begin
                            state        <= SEND;
                            credit_ret_v <= 1'b1;
                        end
                    end
                    SEND: begin
                        if (credit_ret_ack) begin
                            state        <= ARM;
                            credit_ret_v <= 1'b0;
                            timer        <= '0;
                            if (init_phase && (&nxz)) begin
                                init_done  <= 1'b1;
                                init_phase <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef OCX_TLX_CREDIT_STATS_EN
    always_ff @(posedge tlx_clk) begin
        if (reset || !link_up) begin
            credit_ret_total_vc0 <= '0;
            credit_ret_total_vc1 <= '0;
            credit_ret_total_dcp <= '0;
        end else if (accept) begin
            credit_ret_total_vc0 <= credit_ret_total_vc0 + 16'(credit_ret_vc0);
            credit_ret_total_vc1 <= credit_ret_total_vc1 + 16'(credit_ret_vc1);
            credit_ret_total_dcp <= credit_ret_total_dcp + 16'(credit_ret_dcp0) + 16'(credit_ret_dcp1);
        end
    end
`else
    // default build carries no statistics counters
`endif
endmodule

// File: tb/tb_ocx_tlx_rcv_credit_sched.sv
// Bench for ocx_tlx_rcv_credit_sched: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level credit model.
module tb_ocx_tlx_rcv_credit_sched;
    localparam int TIMEOUT = 64;
    localparam int THRESH  = 8;

    logic       clk = 1'b0;
    logic       rst, link_up, ack;
    logic       vc0_rel, vc1_rel, dcp0_rel, dcp1_rel;
    logic       credit_ret_v, init_done, credit_ovf_err;
    logic [3:0] credit_ret_vc0, credit_ret_vc1;
    logic [5:0] credit_ret_dcp0, credit_ret_dcp1;

    int checks   = 0;
    int failures = 0;

    // model: credits owed per class, the request on the wire, init/error status
    int m_pend[4];
    int m_fld[4];
    int m_wait;
    bit m_up, m_v, m_phase, m_done, m_ovf;

    ocx_tlx_rcv_credit_sched dut (
        .tlx_clk(clk), .reset(rst), .link_up(link_up),
        .vc0_release(vc0_rel), .vc1_release(vc1_rel),
        .dcp0_release(dcp0_rel), .dcp1_release(dcp1_rel),
        .credit_ret_ack(ack), .credit_ret_v(credit_ret_v),
        .credit_ret_vc0(credit_ret_vc0), .credit_ret_vc1(credit_ret_vc1),
        .credit_ret_dcp0(credit_ret_dcp0), .credit_ret_dcp1(credit_ret_dcp1),
        .init_done(init_done), .credit_ovf_err(credit_ovf_err)
    );

    always #5 clk = ~clk;

    function automatic int init_of(input int c);
        case (c)
            0: return 16;
            1: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int field_max(input int c);
        return (c < 2) ? 15 : 63;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int r[4];
        int tot;
        bit thr;
        r[0] = vc0_rel ? 1 : 0;
        r[1] = vc1_rel ? 1 : 0;
        r[2] = dcp0_rel ? 1 : 0;
        r[3] = dcp1_rel ? 1 : 0;
        if (rst || !link_up) begin
            if (rst) m_ovf = 0;
            m_up = 0; m_v = 0; m_phase = 0; m_done = 0; m_wait = 0;
            for (int c = 0; c < 4; c++) m_pend[c] = 0;
        end else if (!m_up) begin
            m_up = 1; m_phase = 1;
            for (int c = 0; c < 4; c++) m_pend[c] = init_of(c);
        end else begin
            if (m_v) begin
                for (int c = 0; c < 4; c++) m_pend[c] += r[c] - (ack ? m_fld[c] : 0);
            end else begin
                tot = 0; thr = 0;
                for (int c = 0; c < 4; c++) begin
                    tot += m_pend[c];
                    if (m_pend[c] >= THRESH) thr = 1;
                end
                m_wait = (tot > 0) ? m_wait + 1 : 0;
                if (tot > 0 && (m_phase || thr || m_wait >= TIMEOUT)) begin
                    for (int c = 0; c < 4; c++)
                        m_fld[c] = (m_pend[c] > field_max(c)) ? field_max(c) : m_pend[c];
                    m_v = 1;
                end
                for (int c = 0; c < 4; c++) m_pend[c] += r[c];
            end
            for (int c = 0; c < 4; c++)
                if (m_pend[c] > init_of(c)) begin
                    m_pend[c] = init_of(c);
                    m_ovf = 1;
                end
            if (m_v && ack && !(m_fld[0] == -1)) begin
                // the request completes only if it was already on the wire before this edge
            end
        end
    endtask

    // Ack handling needs to know whether the request was on the wire before the edge,
    // so the SEND branch above runs on the pre-edge m_v; completion is applied here.
    task automatic model_edge();
        bit was_v;
        int tot;
        was_v = m_v && m_up && link_up && !rst;
        model_step();
        if (was_v && ack) begin
            m_v = 0;
            m_wait = 0;
            tot = 0;
            for (int c = 0; c < 4; c++) tot += m_pend[c];
            if (m_phase && tot == 0) begin
                m_done = 1;
                m_phase = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ret_v", int'(credit_ret_v), int'(m_v));
        if (m_v) begin
            chk("fld_vc0", int'(credit_ret_vc0), m_fld[0]);
            chk("fld_vc1", int'(credit_ret_vc1), m_fld[1]);
            chk("fld_dcp0", int'(credit_ret_dcp0), m_fld[2]);
            chk("fld_dcp1", int'(credit_ret_dcp1), m_fld[3]);
        end
        chk("init_done", int'(init_done), int'(m_done));
        chk("ovf_err", int'(credit_ovf_err), int'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (credit_ret_v !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (credit_ret_v !== 1'b1) begin
            failures++;
            $display("FAIL req_wait: credit_ret_v=%0b after %0d cycles, required 1", credit_ret_v, n);
        end
    endtask

    task automatic exp_req(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_vc0"}, int'(credit_ret_vc0), a);
        chk({tag, "_vc1"}, int'(credit_ret_vc1), b);
        chk({tag, "_dcp0"}, int'(credit_ret_dcp0), c);
        chk({tag, "_dcp1"}, int'(credit_ret_dcp1), d);
    endtask

    task automatic ack_req();
        cycle();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
    endtask

    task automatic pulse(input int cls, input int count);
        for (int i = 0; i < count; i++) begin
            vc0_rel = (cls == 0); vc1_rel = (cls == 1);
            dcp0_rel = (cls == 2); dcp1_rel = (cls == 3);
            cycle();
        end
        vc0_rel = 0; vc1_rel = 0; dcp0_rel = 0; dcp1_rel = 0;
    endtask

    task automatic init_seq(input string tag);
        int n;
        wait_req(4, n); exp_req({tag, "_g1"}, 15, 15, 63, 63); ack_req();
        wait_req(4, n); exp_req({tag, "_g2"}, 1, 15, 1, 1); ack_req();
        wait_req(4, n); exp_req({tag, "_g3"}, 0, 2, 0, 0); ack_req();
        chk({tag, "_init_done"}, int'(init_done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int down_cnt;
        rst = 1; link_up = 0; ack = 0;
        vc0_rel = 0; vc1_rel = 0; dcp0_rel = 0; dcp1_rel = 0;
        m_up = 0; m_v = 0; m_phase = 0; m_done = 0; m_ovf = 0; m_wait = 0;
        for (int c = 0; c < 4; c++) begin m_pend[c] = 0; m_fld[c] = 0; end
        cycle(); cycle(); cycle();
        chk("rst_v", int'(credit_ret_v), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_ovf", int'(credit_ovf_err), 0);
        rst = 0;
        cycle();
        link_up = 1;
        init_seq("init");

        // threshold batching
        pulse(1, 8);
        wait_req(2, n);
        exp_req("thresh", 0, 8, 0, 0);
        ack_req();

        // idle flush of a lone credit
        pulse(2, 1);
        wait_req(80, n);
        chk("timeout_lat", n, 64);
        exp_req("timeout", 0, 0, 1, 0);
        ack_req();

        // long ack stall with releases arriving behind the request
        pulse(0, 8);
        wait_req(2, n);
        exp_req("hold_pre", 8, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            dcp1_rel = (i < 5);
            cycle();
        end
        dcp1_rel = 0;
        chk("hold_v", int'(credit_ret_v), 1);
        exp_req("hold_post", 8, 0, 0, 0);
        ack = 1; cycle(); ack = 0;
        wait_req(100, n);
        exp_req("hold_later", 0, 0, 0, 5);
        ack_req();

        // link drop with a request outstanding, then a fresh grant
        pulse(0, 8);
        wait_req(2, n);
        link_up = 0;
        cycle();
        chk("drop_v", int'(credit_ret_v), 0);
        chk("drop_init_done", int'(init_done), 0);
        cycle();
        link_up = 1;
        init_seq("relink");

        // overflow: 17 releases against a 16-credit class with nothing acked
        pulse(0, 17);
        chk("ovf_lit", int'(credit_ovf_err), 1);
        ack = 1; cycle(); ack = 0;
        wait_req(3, n);
        exp_req("sat", 8, 0, 0, 0);
        ack_req();

        // reset while a request is on the wire
        pulse(1, 8);
        wait_req(2, n);
        rst = 1;
        cycle();
        chk("rst_send_v", int'(credit_ret_v), 0);
        chk("rst_send_ovf", int'(credit_ovf_err), 0);
        rst = 0;
        init_seq("post_rst");

        // random traffic
        down_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            vc0_rel  = ($urandom_range(3) == 0);
            vc1_rel  = ($urandom_range(3) == 0);
            dcp0_rel = ($urandom_range(3) == 0);
            dcp1_rel = ($urandom_range(3) == 0);
            ack      = $urandom_range(1);
            if (down_cnt > 0) begin
                link_up = 0;
                down_cnt--;
            end else begin
                link_up = 1;
                if ($urandom_range(499) == 0) down_cnt = $urandom_range(3, 1);
            end
            rst = ($urandom_range(1499) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
